instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the maximum number of in-flight plus buffered instructions.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port n_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port imem_req, output, 1 bit: fetch request valid.
REQ-006 The block SHALL have port imem_addr, output, 32 bits: fetch word address, with bits [1:0] always 0.
REQ-007 The block SHALL have port imem_ready, input, 1 bit: a request is accepted in any cycle where imem_req and imem_ready are both 1.
REQ-008 The block SHALL have port imem_rvalid, input, 1 bit: response valid; responses return in order, latency ≥1 cycle.
REQ-009 The block SHALL have port imem_rdata, input, 32 bits: response instruction word.
REQ-010 The block SHALL have port redirect_valid, input, 1 bit: taken branch/jump from execute.
REQ-011 The block SHALL have port redirect_pc, input, 32 bits: redirect target.
REQ-012 The block SHALL have port id_ready, input, 1 bit: decode accepts the head instruction.
REQ-013 The block SHALL have port if_valid, output, 1 bit: if_instr/if_pc hold a valid instruction.
REQ-014 The block SHALL have port if_instr, output, 32 bits: instruction to decode/immediate generation.
REQ-015 The block SHALL have port if_pc, output, 32 bits: PC of if_instr.

Function
REQ-016 FSM states SHALL be BOOT, FETCH and DRAIN; BOOT lasts exactly one cycle after reset release, then moves to FETCH.
REQ-017 imem_addr SHALL equal the pc register; imem_req SHALL be 1 only in FETCH, when redirect_valid=0, and when (outstanding + fifo_count) < DEPTH.
REQ-018 On an accepted request, pc SHALL advance by 4 (32-bit wrap from 32'hFFFF_FFFC to 0), outstanding SHALL increment, and the request pc SHALL be pushed to an internal pc queue.
REQ-019 On imem_rvalid, {pc-queue head, imem_rdata} SHALL be written to the output FIFO and outstanding SHALL decrement; if_valid SHALL rise the cycle after imem_rvalid (no bypass).
REQ-020 Minimum end-to-end latency SHALL be: request accepted in cycle t, rvalid in t+1, if_valid in t+2.
REQ-021 if_valid SHALL equal FIFO non-empty; if_instr/if_pc SHALL show the FIFO head; the head SHALL pop when if_valid=1 and id_ready=1.
REQ-022 When if_valid=0, if_instr SHALL be 32'h0000_0013 (NOP) and if_pc SHALL be 0.
REQ-023 On redirect_valid, the following SHALL occur: pc <= {redirect_pc[31:2],2'b00}; FIFO and pc queue cleared; drop_cnt <= outstanding minus any rvalid in the same cycle; next state DRAIN if that value >0, else FETCH.
REQ-024 In DRAIN, each imem_rvalid SHALL decrement drop_cnt and be discarded, with no requests issued; the state SHALL return to FETCH when drop_cnt reaches 0.
REQ-025 Simultaneous events SHALL be resolved as follows: redirect beats pop, push and request; a push and a pop in the same cycle are both performed.
REQ-026 A redirect SHALL be honoured in any state, including BOOT and DRAIN; in DRAIN it SHALL reload drop_cnt with the current outstanding count.
REQ-027 imem_rvalid with outstanding=0 and drop_cnt=0 SHALL be ignored and flagged by a simulation assertion.
REQ-028 The counters outstanding, fifo_count and drop_cnt SHALL be $clog2(DEPTH+1) bits wide and SHALL never exceed DEPTH.

Reset
REQ-029 While n_rst=0, the block SHALL hold: state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty, if_valid=0, if_instr=32'h0000_0013, if_pc=0.
REQ-030 Reset asserted mid-transaction SHALL abandon all in-flight requests; responses arriving after reset release with no outstanding count fall under REQ-027.

Structure
REQ-031 Shared package if_pkg SHALL hold the fetch_state_t enum (BOOT/FETCH/DRAIN), NOP_INSTR=32'h0000_0013, and the default RESET_PC.
REQ-032 Sub-module fetch_fifo SHALL be a parameterised DEPTH-entry, 64-bit synchronous FIFO with clear, push, pop, count and async active-low reset; it SHALL be used for both the output FIFO and (32-bit) the pc queue.

Verification
REQ-033 Reset release with imem_ready=1 and 1-cycle memory: imem_addr SHALL be 0 for one BOOT cycle, then requests issue at 0,4,8; first if_valid SHALL show pc=0 two cycles after the first request.
REQ-034 With id_ready=0 held: exactly DEPTH=2 requests SHALL issue and imem_req SHALL stay 0 until a pop occurs.
REQ-035 Redirect to 32'h0000_0103 with 2 outstanding: the next request SHALL be to 32'h0000_0100, issued only after 2 discarded responses; no stale if_valid SHALL appear.
REQ-036 Redirect in the same cycle as rvalid and pop: the FIFO SHALL be empty next cycle and drop_cnt SHALL equal outstanding-1.
REQ-037 pc=32'hFFFF_FFFC fetch: the next imem_addr SHALL be 32'h0000_0000.
REQ-038 Random memory latency 1-5 with random id_ready stalls: the if_pc sequence SHALL be strictly +4 between redirects and every instruction SHALL be delivered exactly once.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear; used as the fetch output buffer and as
// the queue of PCs whose responses are still in flight.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: every read is qualified by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues in-order word fetches, buffers {pc, instr} for
// decode, and flushes/drains in-flight responses on a redirect.
//   state | meaning
//   BOOT  | single cycle after reset release, no requests
//   FETCH | issue requests while in-flight + buffered < DEPTH
//   DRAIN | discard responses belonging to the pre-redirect stream
module instr_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] pcq_count;
    logic [CW-1:0] flush_cnt;
    logic [63:0]   fifo_head;
    logic [31:0]   pcq_head;
    logic          accept;
    logic          rsp_hit;
    logic          rsp_keep;
    logic          rsp_drop;
    logic          head_pop;

    assign imem_addr = pc;
    assign accept    = imem_req && imem_ready;
    // A response with nothing in flight is stray and must not touch any state.
    assign rsp_hit   = imem_rvalid && (outstanding != '0);
    assign rsp_drop  = rsp_hit && (drop_cnt != '0);
    assign rsp_keep  = rsp_hit && (drop_cnt == '0) && !redirect_valid;
    assign flush_cnt = outstanding - CW'(rsp_hit);
    assign if_valid  = (fifo_count != '0);
    assign head_pop  = if_valid && id_ready && !redirect_valid;
    assign if_instr  = if_valid ? fifo_head[31:0]  : NOP_INSTR;
    assign if_pc     = if_valid ? fifo_head[63:32] : 32'h0000_0000;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= BOOT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        case (state)
            BOOT:  state_nxt = FETCH;
            FETCH: imem_req = !redirect_valid &&
                              (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH));
            DRAIN: begin
                if (drop_cnt == '0 || (rsp_drop && drop_cnt == CW'(1))) state_nxt = FETCH;
            end
            default: state_nxt = BOOT;
        endcase
        if (redirect_valid) state_nxt = (flush_cnt != '0) ? DRAIN : FETCH;
    end

    // outstanding keeps counting requests that will be dropped, so a redirect
    // during DRAIN reloads drop_cnt with exactly what is still in flight.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pc          <= RESET_PC & 32'hFFFF_FFFC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            pc          <= redirect_pc & 32'hFFFF_FFFC;
            outstanding <= flush_cnt;
            drop_cnt    <= flush_cnt;
        end else begin
            if (accept) pc <= pc + 32'd4;
            outstanding <= outstanding + CW'(accept) - CW'(rsp_hit);
            if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_pc_queue (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (redirect_valid),
        .push  (accept),
        .din   (pc),
        .pop   (rsp_keep),
        .dout  (pcq_head),
        .count (pcq_count)
    );

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_out_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (redirect_valid),
        .push  (rsp_keep),
        .din   ({pcq_head, imem_rdata}),
        .pop   (head_pop),
        .dout  (fifo_head),
        .count (fifo_count)
    );

    a_stray_rsp: assert property (@(posedge clk) disable iff (!n_rst)
        imem_rvalid |-> (outstanding != '0))
        else $error("instr_fetch: imem_rvalid with nothing outstanding");

    a_pcq_track: assert property (@(posedge clk) disable iff (!n_rst)
        pcq_count == (outstanding - drop_cnt))
        else $error("instr_fetch: pc queue out of step with outstanding count");

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// latency/stall/redirect run checked against a stream-level reference model.
module tb_instr_fetch;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    typedef struct { logic [31:0] addr; int due; } rsp_t;
    rsp_t mq[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_due = -1;
    int lat_min = 1;
    int lat_max = 1;
    int acc_since = 0;
    int del_since = 0;
    int n_del = 0;
    logic [31:0] exp_req = 32'h0;
    logic [31:0] exp_del = 32'h0;

    logic        o_req, o_ifv, o_rv, o_acc, o_pop;
    logic [31:0] o_addr, o_ifpc, o_ifinstr;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_96E1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, let them settle, observe, update the
    // memory model and the expected instruction stream, then cross the edge.
    task automatic step(input logic rdy, input logic idr, input logic redir, input logic [31:0] rpc);
        int due;
        imem_ready     = rdy;
        id_ready       = idr;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = data_of(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        o_rv      = imem_rvalid;
        o_req     = imem_req;
        o_addr    = imem_addr;
        o_ifv     = if_valid;
        o_ifpc    = if_pc;
        o_ifinstr = if_instr;
        o_acc     = o_req && rdy;
        o_pop     = o_ifv && idr && !redir;
        chk("addr_align", {30'd0, o_addr[1:0]}, 32'd0);
        if (!o_ifv) begin
            chk("idle_instr_nop", o_ifinstr, NOP_INSTR);
            chk("idle_pc_zero", o_ifpc, 32'd0);
        end
        if (redir) begin
            chk("req_during_redirect", 32'(o_req), 32'd0);
            exp_req   = {rpc[31:2], 2'b00};
            exp_del   = exp_req;
            acc_since = 0;
            del_since = 0;
        end
        if (o_acc) begin
            chk("req_addr_seq", o_addr, exp_req);
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr: o_addr, due: due});
            exp_req = exp_req + 32'd4;
            acc_since++;
        end
        if (o_pop) begin
            chk("deliver_pc", o_ifpc, exp_del);
            chk("deliver_instr", o_ifinstr, data_of(exp_del));
            exp_del = exp_del + 32'd4;
            del_since++;
            n_del++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Redirect with the memory port closed and wait out all stale responses.
    task automatic fresh(input logic [31:0] target);
        step(1'b0, 1'b1, 1'b1, target);
        for (int i = 0; i < 16 && mq.size() > 0; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("fresh_drained", 32'(mq.size()), 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int rv_cnt;
        int n_before;
        logic found;
        logic stale;
        logic [31:0] wrap_addr [3];

        // Reset hold
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_ifv", 32'(if_valid), 32'd0);
        chk("rst_instr", if_instr, NOP_INSTR);
        chk("rst_pc", if_pc, 32'd0);
        n_rst = 1'b1;

        // Boot cycle, first requests, first delivery
        lat_min = 1; lat_max = 1;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("boot_req", 32'(o_req), 32'd0);
        chk("boot_addr", o_addr, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("first_req", 32'(o_req), 32'd1);
        chk("first_addr", o_addr, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("second_req", 32'(o_req), 32'd1);
        chk("second_addr", o_addr, 32'h4);
        chk("no_bypass_ifv", 32'(o_ifv), 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("first_ifv", 32'(o_ifv), 32'd1);
        chk("first_ifpc", o_ifpc, 32'h0);
        chk("first_instr", o_ifinstr, data_of(32'h0));
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            found = o_acc;
        end
        chk("third_req_seen", 32'(found), 32'd1);
        chk("third_addr", o_addr, 32'h8);

        // Decode stalled: only DEPTH requests, resume after a pop
        fresh(32'h0000_0200);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            if (o_acc) cnt++;
        end
        chk("stall_req_count", 32'(cnt), 32'd2);
        chk("stall_req_low", 32'(o_req), 32'd0);
        chk("stall_ifv", 32'(o_ifv), 32'd1);
        chk("stall_ifpc", o_ifpc, 32'h200);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("stall_pop_req_low", 32'(o_req), 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("req_after_pop", 32'(o_req), 32'd1);

        // Redirect with two in flight: both discarded before the new fetch
        lat_min = 4; lat_max = 4;
        fresh(32'h0000_0300);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("drain_setup_acc0", 32'(o_acc), 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("drain_setup_acc1", 32'(o_acc), 32'd1);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        rv_cnt = 0;
        stale = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (o_req) found = 1'b1;
            else begin
                if (o_rv) rv_cnt++;
                if (o_ifv) stale = 1'b1;
            end
        end
        chk("drain_req_seen", 32'(found), 32'd1);
        chk("drain_new_addr", o_addr, 32'h100);
        chk("drain_discarded", 32'(rv_cnt), 32'd2);
        chk("drain_no_stale", 32'(stale), 32'd0);

        // Redirect coinciding with rvalid and a head pop
        lat_min = 1; lat_max = 1;
        fresh(32'h0000_0400);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0500);
        chk("coinc_ifv", 32'(o_ifv), 32'd1);
        chk("coinc_rv", 32'(o_rv), 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("coinc_fifo_empty", 32'(o_ifv), 32'd0);
        chk("coinc_req_now", 32'(o_req), 32'd1);
        chk("coinc_addr", o_addr, 32'h500);

        // PC wrap at the top of the address space
        fresh(32'hFFFF_FFF8);
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (o_acc) begin
                wrap_addr[cnt] = o_addr;
                cnt++;
            end
        end
        chk("wrap_count", 32'(cnt), 32'd3);
        chk("wrap_top", wrap_addr[1], 32'hFFFF_FFFC);
        chk("wrap_zero", wrap_addr[2], 32'h0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Random latency, stalls and redirects
        lat_min = 1; lat_max = 5;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(3, 0) != 0,
                 $urandom_range(4, 0) > 1,
                 $urandom_range(49, 0) == 0,
                 $urandom);
        end
        n_before = n_del;
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rand_progress", 32'(n_del > n_before), 32'd1);
        for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("rand_mem_idle", 32'(mq.size()), 32'd0);
        chk("rand_ifv_empty", 32'(o_ifv), 32'd0);
        chk("rand_exactly_once", 32'(del_since), 32'(acc_since));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
